// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative RV32M divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_unit_pkg;

   localparam int ID_W       = 4;
   localparam int DIV_CYCLES = 32;

   typedef logic [ID_W-1:0] instruction_id_t;

   // Issue-side request packet; flags are pre-computed by issue.
   typedef struct packed {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [1:0]  op;            // 00 DIV, 01 DIVU, 10 REM, 11 REMU
      logic        reuse_result;
      logic        overflow;
      logic        div_zero;
   } div_inputs_t;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_DIVIDE,
      DIV_SIGN,
      DIV_DONE
   } div_state_t;

   // Two's-complement negation, 32 bits wide (so |0x80000000| stays 0x80000000).
   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Unsigned restoring shift-subtract divider, one quotient bit per cycle.
// Latency: start at edge T, final step at edge T+32, results valid from then on.
// Backpressure: none; a new start simply reloads the datapath.
module div_radix2_core
   import div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic [31:0] o_quotient,
   output logic [31:0] o_remainder,
   output logic        o_complete
);

   localparam int                CNT_W = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV_CYCLES - 1);

   logic [31:0]      r_rem;
   logic [31:0]      r_quo;
   logic [31:0]      r_div;
   logic [CNT_W-1:0] r_count;
   logic             r_busy;

   logic [32:0]      w_rem_sh;
   logic [32:0]      w_trial;

   // Shift the partial remainder left by one, pulling in the next dividend bit;
   // the borrow (bit 32) of the 33-bit trial subtraction decides the step.
   assign w_rem_sh = {r_rem, r_quo[31]};
   assign w_trial  = w_rem_sh - {1'b0, r_div};

   // Load on start, then run one restoring step per cycle until the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem   <= '0;
         r_quo   <= '0;
         r_div   <= '0;
         r_count <= '0;
         r_busy  <= 1'b0;
      end else if (i_start) begin
         r_rem   <= '0;
         r_quo   <= i_dividend;
         r_div   <= i_divisor;
         r_count <= '0;
         r_busy  <= 1'b1;
      end else if (r_busy) begin
         if (!w_trial[32]) begin
            r_rem <= w_trial[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
         end else begin
            r_rem <= w_rem_sh[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
         end
         r_count <= r_count + 1'b1;
         if (r_count == LAST) begin
            r_busy <= 1'b0;
         end
      end
   end

   // Complete flags the cycle whose closing edge performs the final step.
   assign o_complete  = r_busy && (r_count == LAST);
   assign o_quotient  = r_quo;
   assign o_remainder = r_rem;

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: sign handling, special cases, result reuse, handshake.
// Latency: 34 cycles for a real divide, 1 cycle for div-by-zero/overflow/reuse.
// Backpressure: ready low while busy; result held with done until wb_ack.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  div_inputs_t     div_inputs,
   input  logic            new_request,
   input  instruction_id_t id_in,
   output logic            ready,
   output logic            done,
   output instruction_id_t id_out,
   output logic [XLEN-1:0] result,
   input  logic            wb_ack
);

   div_state_t      r_state;
   logic            r_is_rem;
   instruction_id_t r_id;
   logic            r_quo_neg;
   logic            r_rem_neg;
   logic [XLEN-1:0] r_result;
   logic [31:0]     r_saved_quo;
   logic [31:0]     r_saved_rem;

   logic            w_accept;
   logic            w_special;
   logic            w_signed;
   logic [31:0]     w_abs_rs1;
   logic [31:0]     w_abs_rs2;
   logic            w_core_start;
   logic [31:0]     w_core_quo;
   logic [31:0]     w_core_rem;
   logic            w_core_complete;
   logic [31:0]     w_quo_fix;
   logic [31:0]     w_rem_fix;

   assign w_accept  = new_request && (r_state == DIV_IDLE);
   assign w_special = div_inputs.div_zero | div_inputs.overflow | div_inputs.reuse_result;
   assign w_signed  = ~div_inputs.op[0];

   // Only signed ops take magnitudes; the core always works unsigned.
   assign w_abs_rs1 = (w_signed && div_inputs.rs1[31]) ? neg32(div_inputs.rs1) : div_inputs.rs1;
   assign w_abs_rs2 = (w_signed && div_inputs.rs2[31]) ? neg32(div_inputs.rs2) : div_inputs.rs2;

   assign w_core_start = w_accept && !w_special;

   div_radix2_core u_core (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (w_core_start),
      .i_dividend  (w_abs_rs1),
      .i_divisor   (w_abs_rs2),
      .o_quotient  (w_core_quo),
      .o_remainder (w_core_rem),
      .o_complete  (w_core_complete)
   );

   // Restore signs: quotient negative when operand signs differ, remainder follows rs1.
   assign w_quo_fix = r_quo_neg ? neg32(w_core_quo) : w_core_quo;
   assign w_rem_fix = r_rem_neg ? neg32(w_core_rem) : w_core_rem;

   // Handshake FSM; captures op kind, id and sign fixups at accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= DIV_IDLE;
         r_is_rem  <= 1'b0;
         r_id      <= '0;
         r_quo_neg <= 1'b0;
         r_rem_neg <= 1'b0;
      end else begin
         case (r_state)
            DIV_IDLE: begin
               if (w_accept) begin
                  r_is_rem  <= div_inputs.op[1];
                  r_id      <= id_in;
                  r_quo_neg <= w_signed & (div_inputs.rs1[31] ^ div_inputs.rs2[31]);
                  r_rem_neg <= w_signed & div_inputs.rs1[31];
                  r_state   <= w_special ? DIV_DONE : DIV_DIVIDE;
               end
            end
            DIV_DIVIDE: begin
               if (w_core_complete) begin
                  r_state <= DIV_SIGN;
               end
            end
            DIV_SIGN: begin
               r_state <= DIV_DONE;
            end
            DIV_DONE: begin
               if (wb_ack) begin
                  r_state <= DIV_IDLE;
               end
            end
            default: begin
               r_state <= DIV_IDLE;
            end
         endcase
      end
   end

   // Result and saved quotient/remainder; special cases resolve at accept,
   // with div_zero taking priority over overflow over reuse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result    <= '0;
         r_saved_quo <= '0;
         r_saved_rem <= '0;
      end else if (w_accept && div_inputs.div_zero) begin
         r_saved_quo <= 32'hFFFF_FFFF;
         r_saved_rem <= div_inputs.rs1;
         r_result    <= div_inputs.op[1] ? div_inputs.rs1 : 32'hFFFF_FFFF;
      end else if (w_accept && div_inputs.overflow) begin
         r_saved_quo <= 32'h8000_0000;
         r_saved_rem <= 32'h0;
         r_result    <= div_inputs.op[1] ? 32'h0 : 32'h8000_0000;
      end else if (w_accept && div_inputs.reuse_result) begin
         r_result    <= div_inputs.op[1] ? r_saved_rem : r_saved_quo;
      end else if (r_state == DIV_SIGN) begin
         r_saved_quo <= w_quo_fix;
         r_saved_rem <= w_rem_fix;
         r_result    <= r_is_rem ? w_rem_fix : w_quo_fix;
      end
   end

   assign ready  = (r_state == DIV_IDLE);
   assign done   = (r_state == DIV_DONE);
   assign id_out = r_id;
   assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: reference results from native SV division.
// Latency: checks 34-cycle divides and 1-cycle special/reuse results.
// Backpressure: holds wb_ack low to confirm done/result/id stay stable.
module tb_div_unit;
   import div_unit_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n;
   div_inputs_t     div_inputs;
   logic            new_request;
   instruction_id_t id_in;
   logic            ready;
   logic            done;
   instruction_id_t id_out;
   logic [31:0]     result;
   logic            wb_ack;

   always #5 clk = ~clk;

   div_unit #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .div_inputs  (div_inputs),
      .new_request (new_request),
      .id_in       (id_in),
      .ready       (ready),
      .done        (done),
      .id_out      (id_out),
      .result      (result),
      .wb_ack      (wb_ack)
   );

   typedef struct {
      logic [31:0]     res;
      instruction_id_t id;
      int              lat;
   } exp_t;

   exp_t            sb[$];
   int              n_checks = 0;
   int              n_errors = 0;
   logic [31:0]     m_quo = '0;
   logic [31:0]     m_rem = '0;
   instruction_id_t next_id = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model following RISC-V M semantics, with its own saved state.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic reuse, output logic [31:0] res, output int lat);
      logic [31:0] q, r;
      int          sa, sbv;
      logic        dz, ov;
      dz = (b == 32'h0);
      ov = !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      lat = 1;
      if (dz) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (ov) begin
         q = 32'h8000_0000; r = 32'h0;
      end else if (reuse) begin
         res = op[1] ? m_rem : m_quo;
         return;
      end else if (op[0]) begin
         q = a / b; r = a % b; lat = 34;
      end else begin
         sa = a; sbv = b;
         q = sa / sbv; r = sa % sbv; lat = 34;
      end
      m_quo = q; m_rem = r;
      res = op[1] ? r : q;
   endtask

   task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                            input logic reuse, input instruction_id_t id);
      div_inputs.rs1          = a;
      div_inputs.rs2          = b;
      div_inputs.op           = op;
      div_inputs.reuse_result = reuse;
      div_inputs.div_zero     = (b == 32'h0);
      div_inputs.overflow     = !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      id_in                   = id;
      new_request             = 1'b1;
   endtask

   // Issue one op, wait for done (bounded), compare against the scoreboard,
   // optionally hold off wb_ack, then acknowledge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic reuse, input int hold, input int pulse_at, input string tag);
      logic [31:0] res;
      int          lat;
      exp_t        e;
      model(a, b, op, reuse, res, lat);
      sb.push_back('{res: res, id: next_id, lat: lat});
      @(negedge clk);
      check({tag, " ready"}, 32'(ready), 32'd1);
      drive_req(a, b, op, reuse, next_id);
      next_id = next_id + 1'b1;
      @(posedge clk);
      @(negedge clk);
      new_request = 1'b0;
      div_inputs  = div_inputs_t'({$urandom, $urandom, $urandom});
      lat = 1;
      while (!done && lat < 200) begin
         if (lat == pulse_at) new_request = 1'b1;
         @(negedge clk);
         new_request = 1'b0;
         lat++;
      end
      e = sb.pop_front();
      check({tag, " latency"}, 32'(lat), 32'(e.lat));
      check({tag, " result"}, result, e.res);
      check({tag, " id"}, 32'(id_out), 32'(e.id));
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check({tag, " hold done"}, 32'(done), 32'd1);
         check({tag, " hold result"}, result, e.res);
         check({tag, " hold id"}, 32'(id_out), 32'(e.id));
      end
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      check({tag, " done after ack"}, 32'(done), 32'd0);
      check({tag, " ready after ack"}, 32'(ready), 32'd1);
   endtask

   initial begin
      rst_n       = 1'b0;
      new_request = 1'b0;
      wb_ack      = 1'b0;
      id_in       = '0;
      div_inputs  = '0;
      repeat (3) @(negedge clk);
      check("reset ready", 32'(ready), 32'd1);
      check("reset done", 32'(done), 32'd0);
      check("reset result", result, 32'h0);
      check("reset id", 32'(id_out), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(32'd100, 32'd7, 2'b01, 1'b0, 5, -1, "divu_100_7");
      run_op(32'hFFFF_FFF9, 32'd2, 2'b00, 1'b0, 0, -1, "div_m7_2");
      run_op(32'hFFFF_FFF9, 32'd2, 2'b10, 1'b1, 0, -1, "reuse_rem");
      run_op(32'hFFFF_FFF9, 32'd2, 2'b00, 1'b1, 0, -1, "reuse_quo");
      run_op(32'd5, 32'd0, 2'b01, 1'b0, 0, -1, "divu_by0");
      run_op(32'd5, 32'd0, 2'b11, 1'b0, 2, -1, "remu_by0");
      run_op(32'd9, 32'd3, 2'b10, 1'b1, 0, -1, "reuse_after_by0");
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0, 0, -1, "div_ovf");
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 1'b0, 0, -1, "rem_ovf");
      run_op(32'h8000_0000, 32'd1, 2'b01, 1'b0, 0, 5, "divu_msb_1");
      run_op(32'hFFFF_FFFF, 32'h10, 2'b11, 1'b0, 0, 12, "remu_ff_10");
      run_op(32'h8000_0000, 32'd3, 2'b00, 1'b0, 0, -1, "div_min_3");
      run_op(32'd17, 32'hFFFF_FFFB, 2'b10, 1'b0, 0, -1, "rem_17_m5");

      for (int i = 0; i < 6; i++) begin
         logic [31:0] a, b;
         logic [1:0]  op;
         a  = $urandom;
         b  = $urandom >> $urandom_range(0, 28);
         op = 2'($urandom_range(0, 3));
         if (b == 32'h0) b = 32'd13;
         run_op(a, b, op, 1'b0, 0, -1, "random");
      end

      // Reset mid-divide: in-flight op is dropped and saved results clear.
      @(negedge clk);
      drive_req(32'd1000, 32'd9, 2'b01, 1'b0, next_id);
      @(posedge clk);
      @(negedge clk);
      new_request = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid reset done", 32'(done), 32'd0);
      check("mid reset ready", 32'(ready), 32'd1);
      check("mid reset result", result, 32'h0);
      @(negedge clk);
      check("mid reset id", 32'(id_out), 32'h0);
      check("mid reset done hold", 32'(done), 32'd0);
      rst_n = 1'b1;
      m_quo = '0;
      m_rem = '0;
      repeat (40) begin
         @(negedge clk);
         if (done) check("stray done after reset", 32'(done), 32'd0);
      end
      run_op(32'd1, 32'd1, 2'b00, 1'b1, 0, -1, "reuse_after_reset");
      run_op(32'd1000, 32'd9, 2'b01, 1'b0, 0, -1, "divu_after_reset");
      run_op(32'd1000, 32'd9, 2'b11, 1'b0, 0, -1, "remu_after_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
